dv_run_sequencer: RTL and testbench

//  Parametrised simulation run controller for DV top levels; successor to hand-written reset/run/finish initial blocks.

---
 rtl/dv_run_pkg.sv | 20 ++
 rtl/dv_run_sequencer_counter.sv | 19 +
 rtl/dv_run_sequencer.sv | 122 ++++++++++++
 tb/tb_dv_run_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dv_run_pkg.sv
// Shared types for the DV run sequencer: phase encoding, verdict and default counter width.
package dv_run_pkg;

   localparam int unsigned DEFAULT_CNT_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RESET = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } phase_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      PASS = 2'd1,
      FAIL = 2'd2
   } verdict_e;

endpackage

// File: rtl/dv_run_sequencer_counter.sv
// Clear/enable counter that sticks at all-ones instead of wrapping.
module dv_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/dv_run_sequencer.sv
// Simulation run controller: staggered channel resets, timed run phase, sticky verdict and finish pulse.
module dv_run_sequencer
   import dv_run_pkg::*;
#(
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned RESET_CYCLES   = 4,
   parameter int unsigned STAGGER_CYCLES = 0,
   parameter int unsigned RUN_CYCLES     = 10,
   parameter int unsigned DRAIN_CYCLES   = 0,
   parameter bit          AUTO_START     = 1'b1,
   parameter bit          TIMEOUT_PASS   = 1'b1,
   parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [NUM_CH-1:0] dut_done,
   input  logic              dut_error,
   output logic [NUM_CH-1:0] rst_out,
   output logic [NUM_CH-1:0] rst_n_out,
   output logic [2:0]        phase,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              finish,
   output logic              pass,
   output logic              fail
);

   localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
   // DRAIN always occupies at least one cycle, so 0 and 1 behave alike
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);

   phase_e            state, state_next;
   verdict_e          verdict;
   logic [CNT_W-1:0]  rcnt, dcnt;
   logic [NUM_CH-1:0] release_hold;

   dv_sat_counter #(.W(CNT_W)) u_rcnt (
      .clk    (clk),
      .clear  (reset || (state != RESET)),
      .enable (state == RESET),
      .count  (rcnt)
   );

   dv_sat_counter #(.W(CNT_W)) u_cycle (
      .clk    (clk),
      .clear  (reset || ((state == DONE) && start)),
      .enable ((state == RUN) && (verdict == NONE)),
      .count  (cycle_count)
   );

   dv_sat_counter #(.W(CNT_W)) u_dcnt (
      .clk    (clk),
      .clear  (reset || (state != DRAIN)),
      .enable (state == DRAIN),
      .count  (dcnt)
   );

   for (genvar i = 0; i < NUM_CH; i++) begin : g_release
      localparam logic [CNT_W-1:0] THR = CNT_W'(RESET_CYCLES + i * STAGGER_CYCLES);
      assign release_hold[i] = (rcnt < THR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (AUTO_START || start) state_next = RESET;
         RESET:   if (rcnt == RESET_LAST) state_next = RUN;
         RUN:     if (verdict != NONE) state_next = DRAIN;
         DRAIN:   if (dcnt == DRAIN_LAST) state_next = DONE;
         DONE:    if (start) state_next = RESET;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rst_out = '0;
      verdict = NONE;
      unique case (state)
         IDLE:  rst_out = '1;
         RESET: rst_out = release_hold;
         RUN: begin
            if (dut_error)                  verdict = FAIL;
            else if (&dut_done)             verdict = PASS;
            else if (cycle_count == RUN_LAST) verdict = TIMEOUT_PASS ? PASS : FAIL;
         end
         default: ;
      endcase
   end

   assign rst_n_out = ~rst_out;
   assign phase     = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         pass   <= 1'b0;
         fail   <= 1'b0;
         finish <= 1'b0;
      end else begin
         finish <= (state_next == DONE) && (state != DONE);
         if ((state == RUN) && (verdict != NONE)) begin
            pass <= (verdict == PASS);
            fail <= (verdict == FAIL);
         end else if ((state == DONE) && start) begin
            pass <= 1'b0;
            fail <= 1'b0;
         end
      end
   end

   a_verdict_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0({pass, fail}));
   a_finish_verdict: assert property (@(posedge clk) disable iff (reset) finish |-> (pass || fail));

endmodule

// File: tb/tb_dv_run_sequencer.sv
// Scoreboard bench: stimulus pushes expected verdicts, per-instance monitors check them on finish.
module tb_dv_run_sequencer;

   typedef struct {
      logic        p;
      logic        f;
      logic [31:0] cnt;
      int unsigned fin;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t qa[$];
   exp_t qb[$];

   logic        rst_a, start_a, err_a, fin_a, pass_a, fail_a;
   logic [1:0]  done_a, rout_a, rnout_a;
   logic [2:0]  phase_a;
   logic [31:0] cnt_a;
   logic        rst_b, start_b, err_b, fin_b, pass_b, fail_b;
   logic [1:0]  done_b, rout_b, rnout_b;
   logic [2:0]  phase_b;
   logic [31:0] cnt_b;

   dv_run_sequencer #(
      .NUM_CH(2), .RESET_CYCLES(4), .STAGGER_CYCLES(2), .RUN_CYCLES(10),
      .DRAIN_CYCLES(2), .AUTO_START(1'b1), .TIMEOUT_PASS(1'b1), .CNT_W(32)
   ) dut_a (
      .clk(clk), .reset(rst_a), .start(start_a), .dut_done(done_a), .dut_error(err_a),
      .rst_out(rout_a), .rst_n_out(rnout_a), .phase(phase_a), .cycle_count(cnt_a),
      .finish(fin_a), .pass(pass_a), .fail(fail_a)
   );

   dv_run_sequencer #(
      .NUM_CH(2), .RESET_CYCLES(4), .STAGGER_CYCLES(2), .RUN_CYCLES(10),
      .DRAIN_CYCLES(2), .AUTO_START(1'b0), .TIMEOUT_PASS(1'b0), .CNT_W(32)
   ) dut_b (
      .clk(clk), .reset(rst_b), .start(start_b), .dut_done(done_b), .dut_error(err_b),
      .rst_out(rout_b), .rst_n_out(rnout_b), .phase(phase_b), .cycle_count(cnt_b),
      .finish(fin_b), .pass(pass_b), .fail(fail_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_empty(input bit sel_b, input int bound);
      for (int i = 0; i < bound; i++) begin
         if ((sel_b ? qb.size() : qa.size()) == 0) break;
         tick(1);
      end
      if (sel_b) begin
         if (qb.size() != 0) begin
            chk("b_finish_timeout", 32'(qb.size()), 32'd0);
            qb.delete();
         end
      end else if (qa.size() != 0) begin
         chk("a_finish_timeout", 32'(qa.size()), 32'd0);
         qa.delete();
      end
   endtask

   logic fprev_a = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (fprev_a) chk("a_finish_width", 32'(fin_a), 32'd0);
      fprev_a = fin_a;
      if (!rst_a && fin_a) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_finish", 32'(fin_a), 32'd0);
         end else begin
            e = qa.pop_front();
            chk("a_pass", 32'(pass_a), 32'(e.p));
            chk("a_fail", 32'(fail_a), 32'(e.f));
            chk("a_count", cnt_a, e.cnt);
            chk("a_finish_cycle", cyc, e.fin);
            chk("a_finish_phase", 32'(phase_a), 32'd4);
         end
      end
   end

   logic fprev_b = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (fprev_b) chk("b_finish_width", 32'(fin_b), 32'd0);
      fprev_b = fin_b;
      if (!rst_b && fin_b) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_finish", 32'(fin_b), 32'd0);
         end else begin
            e = qb.pop_front();
            chk("b_pass", 32'(pass_b), 32'(e.p));
            chk("b_fail", 32'(fail_b), 32'(e.f));
            chk("b_count", cnt_b, e.cnt);
            chk("b_finish_cycle", cyc, e.fin);
            chk("b_finish_phase", 32'(phase_b), 32'd4);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      logic [1:0] rst_tab [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
      logic [2:0] ph_tab  [7] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};

      rst_a = 1'b1; start_a = 1'b0; done_a = 2'b00; err_a = 1'b0;
      rst_b = 1'b1; start_b = 1'b0; done_b = 2'b00; err_b = 1'b0;
      tick(3);

      // Instance A: reset values
      chk("a_rst_rst_out", 32'(rout_a), 32'h3);
      chk("a_rst_rst_n_out", 32'(rnout_a), 32'h0);
      chk("a_rst_phase", 32'(phase_a), 32'd0);
      chk("a_rst_count", cnt_a, 32'd0);
      chk("a_rst_finish", 32'(fin_a), 32'd0);
      chk("a_rst_pass", 32'(pass_a), 32'd0);
      chk("a_rst_fail", 32'(fail_a), 32'd0);

      // Staggered release then timeout pass
      rst_a = 1'b0;
      base = cyc;
      qa.push_back('{1'b1, 1'b0, 32'd9, base + 19});
      for (int k = 0; k < 7; k++) begin
         tick(1);
         chk("a_release_rst_out", 32'(rout_a), 32'(rst_tab[k]));
         chk("a_release_phase", 32'(phase_a), 32'(ph_tab[k]));
      end
      wait_empty(1'b0, 40);
      tick(2);
      chk("a_done_hold_phase", 32'(phase_a), 32'd4);
      chk("a_done_hold_pass", 32'(pass_a), 32'd1);
      chk("a_done_hold_count", cnt_a, 32'd9);

      // Restart from DONE, all done at run cycle 5
      start_a = 1'b1; tick(1); start_a = 1'b0;
      base = cyc;
      chk("a_restart_pass", 32'(pass_a), 32'd0);
      chk("a_restart_count", cnt_a, 32'd0);
      chk("a_restart_rst_out", 32'(rout_a), 32'h3);
      chk("a_restart_phase", 32'(phase_a), 32'd1);
      qa.push_back('{1'b1, 1'b0, 32'd5, base + 14});
      tick(11); done_a = 2'b11; tick(1); done_a = 2'b00;
      wait_empty(1'b0, 40);

      // Error wins over done
      start_a = 1'b1; tick(1); start_a = 1'b0;
      base = cyc;
      qa.push_back('{1'b0, 1'b1, 32'd2, base + 11});
      tick(8); done_a = 2'b11; err_a = 1'b1; tick(1); done_a = 2'b00; err_a = 1'b0;
      wait_empty(1'b0, 40);
      tick(1);
      chk("a_err_fail_sticky", 32'(fail_a), 32'd1);
      chk("a_err_pass_clear", 32'(pass_a), 32'd0);

      // Controller reset in the middle of RUN
      start_a = 1'b1; tick(1); start_a = 1'b0;
      tick(9);
      rst_a = 1'b1; tick(1);
      chk("a_midrst_rst_out", 32'(rout_a), 32'h3);
      chk("a_midrst_phase", 32'(phase_a), 32'd0);
      chk("a_midrst_count", cnt_a, 32'd0);
      chk("a_midrst_finish", 32'(fin_a), 32'd0);
      chk("a_midrst_fail", 32'(fail_a), 32'd0);
      rst_a = 1'b0;
      base = cyc;
      qa.push_back('{1'b1, 1'b0, 32'd9, base + 19});
      wait_empty(1'b0, 40);

      // Instance B: manual start, timeout counts as fail
      tick(1);
      rst_b = 1'b0;
      tick(5);
      chk("b_idle_phase", 32'(phase_b), 32'd0);
      chk("b_idle_rst_out", 32'(rout_b), 32'h3);
      start_b = 1'b1; tick(1); start_b = 1'b0;
      base = cyc;
      qb.push_back('{1'b0, 1'b1, 32'd9, base + 18});
      tick(9);
      start_b = 1'b1; tick(1); start_b = 1'b0;
      chk("b_run_start_ignored_phase", 32'(phase_b), 32'd2);
      chk("b_run_start_ignored_count", cnt_b, 32'd4);
      wait_empty(1'b1, 40);
      tick(2);
      chk("b_done_fail_sticky", 32'(fail_b), 32'd1);
      chk("b_done_phase", 32'(phase_b), 32'd4);

      // Rerun from DONE with verdict cleared
      start_b = 1'b1; tick(1); start_b = 1'b0;
      base = cyc;
      chk("b_restart_fail", 32'(fail_b), 32'd0);
      chk("b_restart_pass", 32'(pass_b), 32'd0);
      chk("b_restart_count", cnt_b, 32'd0);
      chk("b_restart_phase", 32'(phase_b), 32'd1);
      qb.push_back('{1'b1, 1'b0, 32'd4, base + 13});
      tick(10); done_b = 2'b11; tick(1); done_b = 2'b00;
      wait_empty(1'b1, 40);
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
